des_block_serializer: RTL

DES_BLOCK_SERIALIZER -- requirements
Module: des_block_serializer

---
 rtl/des_block_serializer_if.sv | 24 ++
 rtl/des_block_serializer.sv | 105 ++++++++++
 2 files changed

// File: rtl/des_block_serializer_if.sv
// Block-in / byte-out handshake bundle for the DES block serializer.
// The master is the upstream permutation stage plus the downstream FIFO side.
// The slave is the serializer itself.
interface des_block_serializer_if;
   logic [63:0] tx_data;
   logic        block_valid;
   logic        block_ready;
   logic [7:0]  tx_byte;
   logic        byte_valid;
   logic        byte_ready;
   logic        last_byte;
   logic        block_done;
   logic        busy;

   modport master (
      output tx_data, block_valid, byte_ready,
      input  block_ready, tx_byte, byte_valid, last_byte, block_done, busy
   );

   modport slave (
      input  tx_data, block_valid, byte_ready,
      output block_ready, tx_byte, byte_valid, last_byte, block_done, busy
   );
endinterface

// File: rtl/des_block_serializer.sv
// DES block serializer: turns 64-bit ciphertext blocks into a byte stream.
// It has one active shift register and a one-deep skid buffer, so consecutive
// blocks stream out with no bubble between them.
module des_block_serializer #(
   parameter int MSB_FIRST = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   des_block_serializer_if.slave  bus
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state_q, state_d;
   logic [63:0] shift_q, shift_d;
   logic [63:0] buf_q, buf_d;
   logic [2:0]  count_q, count_d;
   logic        buf_full_q, buf_full_d;
   logic        block_done_q, block_done_d;

   logic        blk_xfer;
   logic        byte_xfer;
   logic        final_xfer;
   logic [63:0] shifted;

   // Handshake decode; the outgoing byte always sits at the same end of shift_q
   always_comb begin
      blk_xfer   = bus.block_valid && !buf_full_q;
      byte_xfer  = (state_q == SEND) && bus.byte_ready;
      final_xfer = byte_xfer && (count_q == 3'd7);
      shifted    = (MSB_FIRST != 0) ? {shift_q[55:0], 8'h00} : {8'h00, shift_q[63:8]};
   end

   // Next-state logic: load, shift, buffer, and hand over from the buffer
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      buf_d        = buf_q;
      count_d      = count_q;
      buf_full_d   = buf_full_q;
      block_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (blk_xfer) begin
               shift_d = bus.tx_data;
               count_d = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (final_xfer) begin
               block_done_d = 1'b1;
               count_d      = '0;
               if (buf_full_q) begin
                  shift_d    = buf_q;
                  buf_full_d = 1'b0;
               end else if (blk_xfer) begin
                  shift_d = bus.tx_data;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (byte_xfer) begin
                  shift_d = shifted;
                  count_d = count_q + 3'd1;
               end
               if (blk_xfer) begin
                  buf_d      = bus.tx_data;
                  buf_full_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; flush clears everything exactly like reset
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         buf_q        <= '0;
         count_q      <= '0;
         buf_full_q   <= 1'b0;
         block_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         buf_q        <= buf_d;
         count_q      <= count_d;
         buf_full_q   <= buf_full_d;
         block_done_q <= block_done_d;
      end
   end

   assign bus.block_ready = !buf_full_q;
   assign bus.byte_valid  = (state_q == SEND);
   assign bus.tx_byte     = (state_q != SEND) ? 8'h00 :
                            (MSB_FIRST != 0)  ? shift_q[63:56] : shift_q[7:0];
   assign bus.last_byte   = (state_q == SEND) && (count_q == 3'd7);
   assign bus.block_done  = block_done_q;
   assign bus.busy        = (state_q == SEND) || buf_full_q;

endmodule
